frame_buf_sched: RTL

- Ping-pong frame scheduler that shares one 2-bank frame memory (2 x FRAME_LEN words) between a pixel writer and a display reader.
- Generates all memory write/read enables and addresses.
- Tracks which bank holds a complete frame and stalls the writer when its next bank is still being displayed.
- When no newer frame is ready, the reader repeats the last complete frame.

---
 rtl/frame_buf_sched_if.sv | 33 +++
 rtl/frame_buf_sched.sv | 112 +++++++++++
 2 files changed

// File: rtl/frame_buf_sched_if.sv
// frame_buf_sched_if: writer/reader handshakes and frame-memory port bundle
// for frame_buf_sched; master is the pixel/display side, slave the scheduler.
interface frame_buf_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  wr_req_n;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_rdy;
    logic                  rd_req_n;
    logic                  rd_rdy;
    logic                  mem_wr_en_n;
    logic [ADDR_WIDTH:0]   mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_rd_en_n;
    logic [ADDR_WIDTH:0]   mem_rd_addr;
    logic                  wr_frame_done;
    logic                  rd_frame_done;
    logic                  rd_repeat;
    logic [1:0]            full;

    modport master (
        output wr_req_n, wr_data, rd_req_n,
        input  wr_rdy, rd_rdy, mem_wr_en_n, mem_wr_addr, mem_wr_data, mem_rd_en_n,
        input  mem_rd_addr, wr_frame_done, rd_frame_done, rd_repeat, full
    );

    modport slave (
        input  wr_req_n, wr_data, rd_req_n,
        output wr_rdy, rd_rdy, mem_wr_en_n, mem_wr_addr, mem_wr_data, mem_rd_en_n,
        output mem_rd_addr, wr_frame_done, rd_frame_done, rd_repeat, full
    );
endinterface

// File: rtl/frame_buf_sched.sv
// frame_buf_sched: ping-pong scheduler sharing a 2-bank frame memory between a
// pixel writer and a display reader that repeats the last frame when starved.
module frame_buf_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int FRAME_LEN  = 1 << ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    frame_buf_sched_if.slave bus
);
    typedef enum logic {W_FILL, W_WAIT} w_state_t;
    typedef enum logic {R_IDLE, R_READ} r_state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_LEN - 1);

    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;
    logic [1:0]            full, full_n;
    logic                  wr_bank, wr_bank_n, rd_bank, rd_bank_n;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_n, rd_addr, rd_addr_n;
    logic                  wr_en_n, rd_en_n, wr_done, rd_done, rd_rep;
    logic [ADDR_WIDTH:0]   wr_maddr, rd_maddr;
    logic [DATA_WIDTH-1:0] wr_mdata;
    logic                  wa, ra, w_last, r_last, nb, rel;

    assign wa     = !bus.wr_req_n && w_state == W_FILL;
    assign ra     = !bus.rd_req_n && r_state == R_READ;
    assign w_last = wa && wr_addr == LAST;
    assign r_last = ra && rd_addr == LAST;
    assign nb     = ~wr_bank;
    // reader leaves its bank if the other one holds a frame or completes one this edge
    assign rel    = r_last && (full[~rd_bank] || (w_last && wr_bank != rd_bank));

    always_comb begin
        w_next    = w_state;
        r_next    = r_state;
        full_n    = full;
        wr_bank_n = wr_bank;
        rd_bank_n = rd_bank;
        wr_addr_n = wa ? (w_last ? '0 : wr_addr + 1'b1) : wr_addr;
        rd_addr_n = ra ? (r_last ? '0 : rd_addr + 1'b1) : rd_addr;
        if (w_last) begin
            full_n[wr_bank] = 1'b1;
            if (r_state == R_READ && rd_bank == nb && !rel)
                w_next = W_WAIT;
            else
                wr_bank_n = nb;
        end
        if (w_state == W_WAIT && rel && rd_bank == nb) begin
            w_next    = W_FILL;
            wr_bank_n = nb;
        end
        if (r_state == R_IDLE && |full) begin
            r_next    = R_READ;
            rd_bank_n = ~full[0];
            rd_addr_n = '0;
        end
        if (rel) begin
            full_n[rd_bank] = 1'b0;
            rd_bank_n       = ~rd_bank;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state  <= W_FILL;
            r_state  <= R_IDLE;
            full     <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            wr_en_n  <= 1'b1;
            rd_en_n  <= 1'b1;
            wr_maddr <= '0;
            rd_maddr <= '0;
            wr_mdata <= '0;
            wr_done  <= 1'b0;
            rd_done  <= 1'b0;
            rd_rep   <= 1'b0;
        end else begin
            w_state  <= w_next;
            r_state  <= r_next;
            full     <= full_n;
            wr_bank  <= wr_bank_n;
            rd_bank  <= rd_bank_n;
            wr_addr  <= wr_addr_n;
            rd_addr  <= rd_addr_n;
            wr_en_n  <= !wa;
            rd_en_n  <= !ra;
            wr_maddr <= wa ? {wr_bank, wr_addr} : wr_maddr;
            rd_maddr <= ra ? {rd_bank, rd_addr} : rd_maddr;
            wr_mdata <= wa ? bus.wr_data : wr_mdata;
            wr_done  <= w_last;
            rd_done  <= r_last;
            rd_rep   <= r_last && !rel;
        end
    end

    assign bus.wr_rdy        = w_state == W_FILL;
    assign bus.rd_rdy        = r_state == R_READ;
    assign bus.mem_wr_en_n   = wr_en_n;
    assign bus.mem_wr_addr   = wr_maddr;
    assign bus.mem_wr_data   = wr_mdata;
    assign bus.mem_rd_en_n   = rd_en_n;
    assign bus.mem_rd_addr   = rd_maddr;
    assign bus.wr_frame_done = wr_done;
    assign bus.rd_frame_done = rd_done;
    assign bus.rd_repeat     = rd_rep;
    assign bus.full          = full;
endmodule
